// File: rtl/mem_stage_bus_ctrl.sv
// mem_stage_bus_ctrl
//   MEM-stage data-memory access controller. Turns a load/store request into
//   one valid/ready bus transaction, formats the returned load data and holds
//   the pipeline (mem_stall) until the access has completed.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   mem_re, mem_we    load / store request (both high = store)
//   mem_addr          byte address
//   mem_wdata         store data, right-aligned
//   mem_funct3        RV64 load/store funct3 (width + signedness)
//   kill              squash of the MEM-stage instruction; only blocks new requests
//   mem_rdata         formatted load result (registered)
//   mem_stall         stall request to the pipeline stall/flush unit
//   except_misalign   misaligned access, combinational, only while idle
//   except_access     bus error / timeout, one-cycle pulse in DONE
//   bus_req_*         request channel (valid/ready, 8-byte aligned address,
//                     lane-shifted write data, byte-lane write mask)
//   bus_resp_*        response channel (valid, aligned 8-byte data, error)
module mem_stage_bus_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_re,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [2:0]      mem_funct3,
  input  logic            kill,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_stall,
  output logic            except_misalign,
  output logic            except_access,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_req_we,
  output logic [XLEN-1:0] bus_req_addr,
  output logic [XLEN-1:0] bus_req_wdata,
  output logic [7:0]      bus_req_wmask,
  input  logic            bus_resp_valid,
  input  logic [XLEN-1:0] bus_resp_rdata,
  input  logic            bus_resp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:3]   addr_q;
  logic [2:0]        off_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [XLEN-1:0]   wdata_q;
  logic [7:0]        wmask_q;
  logic [XLEN-1:0]   rdata_q;
  logic [7:0]        cnt_q;
  logic              fault_q;

  logic              access;
  logic [2:0]        off;
  logic [3:0]        size;
  logic [2:0]        amask;
  logic              aligned;
  logic [7:0]        wmask;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   ld_sh;
  logic [XLEN-1:0]   ld_fmt;
  logic              launch, accept, take_resp, time_out;

  assign off    = mem_addr[2:0];
  assign access = (mem_re | mem_we) & ~kill;

  // Access size in bytes. Unused store encodings (bit2 set) and 111 fall
  // back to a full doubleword.
  always_comb begin
    size = 4'd8;
    case (mem_funct3)
      3'b000, 3'b100: size = 4'd1;
      3'b001, 3'b101: size = 4'd2;
      3'b010, 3'b110: size = 4'd4;
      default:        size = 4'd8;
    endcase
    if (mem_we && mem_funct3[2]) size = 4'd8;
  end

  // size-1 is 0/1/3/7, so alignment is just the low offset bits under it.
  assign amask    = 3'(size - 4'd1);
  assign aligned  = (off & amask) == 3'd0;
  assign wmask    = mem_we ? (8'((9'd1 << size) - 9'd1) << off) : 8'd0;
  assign wdata_sh = mem_wdata << {off, 3'b000};

  // Load formatting works on the latched offset/funct3 of the in-flight access.
  assign ld_sh = bus_resp_rdata >> {off_q, 3'b000};
  always_comb begin
    ld_fmt = ld_sh;
    case (funct3_q)
      3'b000:  ld_fmt = {{(XLEN-8){ld_sh[7]}},   ld_sh[7:0]};
      3'b001:  ld_fmt = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_fmt = {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}},       ld_sh[7:0]};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}},      ld_sh[15:0]};
      3'b110:  ld_fmt = {{(XLEN-32){1'b0}},      ld_sh[31:0]};
      default: ld_fmt = ld_sh;
    endcase
  end

  // Next state and control strobes.
  always_comb begin
    state_d         = state_q;
    mem_stall       = 1'b0;
    except_misalign = 1'b0;
    launch          = 1'b0;
    accept          = 1'b0;
    take_resp       = 1'b0;
    time_out        = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            launch    = 1'b1;
            mem_stall = 1'b1;
            state_d   = REQ;
          end else begin
            except_misalign = 1'b1;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (bus_req_ready) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (bus_resp_valid) begin
          take_resp = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // cnt_q counts WAIT cycles already spent, so this is cycle TIMEOUT.
          time_out = 1'b1;
          state_d  = DONE;
        end
      end
      // One unstalled cycle lets the instruction leave MEM; going straight to
      // IDLE with the request still present would reissue it.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Idle-path outputs are forced low while reset is held.
    if (rst) begin
      mem_stall       = 1'b0;
      except_misalign = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        addr_q   <= mem_addr[XLEN-1:3];
        off_q    <= off;
        funct3_q <= mem_funct3;
        we_q     <= mem_we;
        wdata_q  <= wdata_sh;
        wmask_q  <= wmask;
        fault_q  <= 1'b0;
      end
      if (accept)                cnt_q <= '0;
      else if (state_q == WAIT)  cnt_q <= cnt_q + 8'd1;
      if (take_resp) begin
        if (bus_resp_err) begin
          fault_q <= 1'b1;
          rdata_q <= '0;
        end else if (!we_q) begin
          rdata_q <= ld_fmt;
        end
      end
      if (time_out) fault_q <= 1'b1;
    end
  end

  assign mem_rdata     = rdata_q;
  assign except_access = (state_q == DONE) & fault_q;
  assign bus_req_valid = (state_q == REQ);
  assign bus_req_we    = we_q;
  assign bus_req_addr  = {addr_q, 3'b000};
  assign bus_req_wdata = wdata_q;
  assign bus_req_wmask = wmask_q;

endmodule
